cpu_control_fsm: RTL and testbench
==================================

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous reset, active-low, sampled on the rising edge of clk.
REQ-003 SHALL have ports OPCODE[5:0] and FUNCT[5:0], both inputs: fields from the instruction register.
REQ-004 SHALL have ports Of and Eq, both 1-bit inputs: ALU overflow and equal flags, valid in the cycle the ALU operates.
REQ-005 SHALL have 1-bit write-enable outputs PC_w, MEM_w, IR_w, RB_w, AB_w, ALU_w and EPC_w.
REQ-006 SHALL have output ULA_c[2:0] with encoding 000 load A, 001 add, 010 sub, 011 and, 111 compare.
REQ-007 SHALL have output M_selector_Memory[1:0]: 0 PC, 1 ALUOut.
REQ-008 SHALL have output M_selector_writereg[1:0]: 0 RT, 1 RD, 2 constant 29.
REQ-009 SHALL have output M_selector_WDATA[2:0]: 0 ALUOut, 1 load data, 7 constant 227.
REQ-010 SHALL have output M_selector_A (1 bit: 0 PC, 1 A) and output M_selector_B[1:0] (0 B, 1 const 4, 2 signext, 3 signext<<2).
REQ-011 SHALL have output M_selector_ALUOut[2:0] selecting next PC: 0 ULA result, 1 ALUOut reg, 2 jump target, 4 exception vector 0x000000FF.

Function
REQ-012 SHALL be a Moore FSM; every output is a function of state only, except the branch PC_w in BRANCH (REQ-020); outputs not listed for a state are 0.
REQ-013 SHALL use states RST, F0, F1, F2, DEC, EX_R, WB_R, EX_I, WB_I, ADDR, LW0, LW1, LW_WB, SW, BRANCH, JUMP, EXC.
REQ-014 RST: RB_w=1, writereg=2, WDATA=7 (reg 29 <= 227); next F0.
REQ-015 F0/F1: Memory=0, MEM_w=0 (two-cycle memory read latency); F0->F1->F2.
REQ-016 F2: IR_w=1, A=0, B=1, ULA_c=001, ALUOut sel=0, PC_w=1 (PC <= PC+4); next DEC.
REQ-017 DEC: AB_w=1, A=0, B=3, ULA_c=001, ALU_w=1 (branch target); next by OPCODE: 0x00 -> EX_R, 0x08 -> EX_I, 0x23/0x2B -> ADDR, 0x04/0x05 -> BRANCH, 0x02 -> JUMP, any other -> EXC.
REQ-018 EX_R: A=1, B=0, ALU_w=1, ULA_c by FUNCT (0x20 add, 0x22 sub, 0x24 and); unknown FUNCT -> EXC; Of=1 on add/sub -> EXC; else WB_R; WB_R: RB_w=1, writereg=1, WDATA=0; next F0.
REQ-019 EX_I: A=1, B=2, ULA_c=001, ALU_w=1; Of=1 -> EXC, else WB_I; WB_I: RB_w=1, writereg=0, WDATA=0; next F0.
REQ-020 BRANCH: A=1, B=0, ULA_c=111, ALUOut sel=1; PC_w=1 iff (OPCODE=0x04 and Eq=1) or (OPCODE=0x05 and Eq=0); next F0.
REQ-021 JUMP: ALUOut sel=2, PC_w=1; next F0.
REQ-022 ADDR: A=1, B=2, ULA_c=001, ALU_w=1 (overflow ignored); next LW0 if 0x23, SW if 0x2B.
REQ-023 LW0/LW1: Memory=1, read wait; LW1 -> LW_WB; LW_WB: RB_w=1, writereg=0, WDATA=1; next F0.
REQ-024 SW: Memory=1, MEM_w=1 for exactly one cycle; next F0.
REQ-025 EXC: A=0, B=1, ULA_c=010, EPC_w=1 (EPC <= PC-4), ALUOut sel=4, PC_w=1; next F0.
REQ-026 MEM_w SHALL never be 1 outside SW; PC_w SHALL never be 1 in the same cycle as MEM_w.

Reset
REQ-027 reset=0 at a clock edge SHALL force state RST regardless of current state, including mid-instruction; while reset=0 all write enables other than RST's RB_w SHALL be 0.
REQ-028 After reset returns to 1, the FSM SHALL perform exactly one RST cycle, then F0.

Verification
REQ-029 Reset low 3 cycles, release -> one cycle RB_w=1/writereg=2/WDATA=7, then F0, F1, F2 with IR_w=1, PC_w=1 in F2.
REQ-030 OPCODE=0x00, FUNCT=0x20, Of=0 -> F0,F1,F2,DEC,EX_R(ULA_c=001),WB_R(RB_w=1, writereg=1): 6 cycles.
REQ-031 OPCODE=0x04 with Eq=1 -> PC_w=1 with ALUOut sel=1 in BRANCH; Eq=0 -> PC_w=0; OPCODE=0x05 inverse.
REQ-032 OPCODE=0x2B -> MEM_w=1 exactly one cycle, Memory=1; OPCODE=0x23 -> LW_WB with WDATA=1 on cycle 8.
REQ-033 OPCODE=0x08 with Of=1, and OPCODE=0x3F -> EXC: EPC_w=1, PC_w=1, ALUOut sel=4, RB_w never 1 for that instruction.
REQ-034 reset=0 asserted during LW1 -> next state RST, no RB_w from LW_WB, MEM_w stays 0.

Source files
------------

// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the multicycle CPU control FSM and its datapath.
// The master side is the FSM; the slave side is the datapath.
interface cpu_control_fsm_if;
    logic [5:0] OPCODE;
    logic [5:0] FUNCT;
    logic       Of;
    logic       Eq;

    logic       PC_w;
    logic       MEM_w;
    logic       IR_w;
    logic       RB_w;
    logic       AB_w;
    logic       ALU_w;
    logic       EPC_w;
    logic [2:0] ULA_c;
    logic [1:0] M_selector_Memory;
    logic [1:0] M_selector_writereg;
    logic [2:0] M_selector_WDATA;
    logic       M_selector_A;
    logic [1:0] M_selector_B;
    logic [2:0] M_selector_ALUOut;

    modport master (
        input  OPCODE, FUNCT, Of, Eq,
        output PC_w, MEM_w, IR_w, RB_w, AB_w, ALU_w, EPC_w, ULA_c,
               M_selector_Memory, M_selector_writereg, M_selector_WDATA,
               M_selector_A, M_selector_B, M_selector_ALUOut
    );

    modport slave (
        output OPCODE, FUNCT, Of, Eq,
        input  PC_w, MEM_w, IR_w, RB_w, AB_w, ALU_w, EPC_w, ULA_c,
               M_selector_Memory, M_selector_writereg, M_selector_WDATA,
               M_selector_A, M_selector_B, M_selector_ALUOut
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Moore control FSM for a multicycle MIPS-like CPU: fetch, decode, R/I-type ALU ops,
// load/store, branch, jump and overflow/illegal-opcode exception entry.
module cpu_control_fsm (
    input  logic                  clk,
    input  logic                  reset,
    cpu_control_fsm_if.master     bus
);
    localparam logic [5:0] OpR    = 6'h00;
    localparam logic [5:0] OpJ    = 6'h02;
    localparam logic [5:0] OpBeq  = 6'h04;
    localparam logic [5:0] OpBne  = 6'h05;
    localparam logic [5:0] OpAddi = 6'h08;
    localparam logic [5:0] OpLw   = 6'h23;
    localparam logic [5:0] OpSw   = 6'h2B;

    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnAnd  = 6'h24;

    localparam logic [2:0] UlaAdd = 3'b001;
    localparam logic [2:0] UlaSub = 3'b010;
    localparam logic [2:0] UlaAnd = 3'b011;
    localparam logic [2:0] UlaCmp = 3'b111;

    typedef enum logic [4:0] {
        StRst, StF0, StF1, StF2, StDec, StExR, StWbR, StExI, StWbI,
        StAddr, StLw0, StLw1, StLwWb, StSw, StBranch, StJump, StExc
    } state_e;

    state_e state_q, state_d;

    logic       pc_w, mem_w, ir_w, rb_w, ab_w, alu_w, epc_w;
    logic [2:0] ula_c;
    logic [1:0] sel_mem;
    logic [1:0] sel_wreg;
    logic [2:0] sel_wdata;
    logic       sel_a;
    logic [1:0] sel_b;
    logic [2:0] sel_out;

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pc_w      = 1'b0;
        mem_w     = 1'b0;
        ir_w      = 1'b0;
        rb_w      = 1'b0;
        ab_w      = 1'b0;
        alu_w     = 1'b0;
        epc_w     = 1'b0;
        ula_c     = 3'b000;
        sel_mem   = 2'd0;
        sel_wreg  = 2'd0;
        sel_wdata = 3'd0;
        sel_a     = 1'b0;
        sel_b     = 2'd0;
        sel_out   = 3'd0;

        case (state_q)
            StRst: begin
                rb_w      = 1'b1;
                sel_wreg  = 2'd2;
                sel_wdata = 3'd7;
                state_d   = StF0;
            end
            StF0: state_d = StF1;
            StF1: state_d = StF2;
            StF2: begin
                ir_w    = 1'b1;
                sel_b   = 2'd1;
                ula_c   = UlaAdd;
                pc_w    = 1'b1;
                state_d = StDec;
            end
            StDec: begin
                // Speculatively compute the branch target into ALUOut.
                ab_w  = 1'b1;
                sel_b = 2'd3;
                ula_c = UlaAdd;
                alu_w = 1'b1;
                case (bus.OPCODE)
                    OpR:         state_d = StExR;
                    OpAddi:      state_d = StExI;
                    OpLw, OpSw:  state_d = StAddr;
                    OpBeq, OpBne: state_d = StBranch;
                    OpJ:         state_d = StJump;
                    default:     state_d = StExc;
                endcase
            end
            StExR: begin
                sel_a = 1'b1;
                alu_w = 1'b1;
                case (bus.FUNCT)
                    FnAdd: begin
                        ula_c   = UlaAdd;
                        state_d = bus.Of ? StExc : StWbR;
                    end
                    FnSub: begin
                        ula_c   = UlaSub;
                        state_d = bus.Of ? StExc : StWbR;
                    end
                    FnAnd: begin
                        ula_c   = UlaAnd;
                        state_d = StWbR;
                    end
                    default: state_d = StExc;
                endcase
            end
            StWbR: begin
                rb_w     = 1'b1;
                sel_wreg = 2'd1;
                state_d  = StF0;
            end
            StExI: begin
                sel_a   = 1'b1;
                sel_b   = 2'd2;
                ula_c   = UlaAdd;
                alu_w   = 1'b1;
                state_d = bus.Of ? StExc : StWbI;
            end
            StWbI: begin
                rb_w    = 1'b1;
                state_d = StF0;
            end
            StAddr: begin
                sel_a   = 1'b1;
                sel_b   = 2'd2;
                ula_c   = UlaAdd;
                alu_w   = 1'b1;
                state_d = (bus.OPCODE == OpLw) ? StLw0 : StSw;
            end
            StLw0: begin
                sel_mem = 2'd1;
                state_d = StLw1;
            end
            StLw1: begin
                sel_mem = 2'd1;
                state_d = StLwWb;
            end
            StLwWb: begin
                rb_w      = 1'b1;
                sel_wdata = 3'd1;
                state_d   = StF0;
            end
            StSw: begin
                sel_mem = 2'd1;
                mem_w   = 1'b1;
                state_d = StF0;
            end
            StBranch: begin
                sel_a   = 1'b1;
                ula_c   = UlaCmp;
                sel_out = 3'd1;
                pc_w    = ((bus.OPCODE == OpBeq) && bus.Eq) ||
                          ((bus.OPCODE == OpBne) && !bus.Eq);
                state_d = StF0;
            end
            StJump: begin
                sel_out = 3'd2;
                pc_w    = 1'b1;
                state_d = StF0;
            end
            StExc: begin
                // EPC <= PC-4 undoes the fetch increment; PC jumps to the vector.
                sel_b   = 2'd1;
                ula_c   = UlaSub;
                epc_w   = 1'b1;
                sel_out = 3'd4;
                pc_w    = 1'b1;
                state_d = StF0;
            end
            default: state_d = StRst;
        endcase

        // Reset overrides any state so no half-finished instruction can write anything.
        if (!reset) begin
            state_d   = StRst;
            pc_w      = 1'b0;
            mem_w     = 1'b0;
            ir_w      = 1'b0;
            ab_w      = 1'b0;
            alu_w     = 1'b0;
            epc_w     = 1'b0;
            ula_c     = 3'b000;
            sel_mem   = 2'd0;
            sel_a     = 1'b0;
            sel_b     = 2'd0;
            sel_out   = 3'd0;
            rb_w      = 1'b1;
            sel_wreg  = 2'd2;
            sel_wdata = 3'd7;
        end
    end

    assign bus.PC_w                = pc_w;
    assign bus.MEM_w               = mem_w;
    assign bus.IR_w                = ir_w;
    assign bus.RB_w                = rb_w;
    assign bus.AB_w                = ab_w;
    assign bus.ALU_w               = alu_w;
    assign bus.EPC_w               = epc_w;
    assign bus.ULA_c               = ula_c;
    assign bus.M_selector_Memory   = sel_mem;
    assign bus.M_selector_writereg = sel_wreg;
    assign bus.M_selector_WDATA    = sel_wdata;
    assign bus.M_selector_A        = sel_a;
    assign bus.M_selector_B        = sel_b;
    assign bus.M_selector_ALUOut   = sel_out;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: an instruction-level model expands each instruction into the
// expected per-cycle control vector sequence; a negedge process compares every cycle.
module tb_cpu_control_fsm;
    typedef struct packed {
        logic       pc_w;
        logic       mem_w;
        logic       ir_w;
        logic       rb_w;
        logic       ab_w;
        logic       alu_w;
        logic       epc_w;
        logic [2:0] ula;
        logic [1:0] mem_sel;
        logic [1:0] wreg;
        logic [2:0] wdata;
        logic       a_sel;
        logic [1:0] b_sel;
        logic [2:0] out_sel;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    cpu_control_fsm_if bus ();

    cpu_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    rec_t  exp_q[$];
    string tag_q[$];
    rec_t  plan_q[$];
    string ptag_q[$];
    rec_t  obs[$];

    function automatic rec_t cur();
        rec_t r;
        r.pc_w    = bus.PC_w;
        r.mem_w   = bus.MEM_w;
        r.ir_w    = bus.IR_w;
        r.rb_w    = bus.RB_w;
        r.ab_w    = bus.AB_w;
        r.alu_w   = bus.ALU_w;
        r.epc_w   = bus.EPC_w;
        r.ula     = bus.ULA_c;
        r.mem_sel = bus.M_selector_Memory;
        r.wreg    = bus.M_selector_writereg;
        r.wdata   = bus.M_selector_WDATA;
        r.a_sel   = bus.M_selector_A;
        r.b_sel   = bus.M_selector_B;
        r.out_sel = bus.M_selector_ALUOut;
        return r;
    endfunction

    always @(negedge clk) begin
        rec_t  a;
        rec_t  e;
        string t;
        a = cur();
        obs.push_back(a);
        checks++;
        if (a.mem_w && a.pc_w) begin
            failures++;
            $display("FAIL mem_pc_exclusive t=%0t actual MEM_w=%b PC_w=%b required not both 1",
                     $time, a.mem_w, a.pc_w);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL step_%s t=%0t actual=%h required=%h", t, $time, a, e);
            end
        end
    end

    // ---------------- instruction-level model ----------------
    function automatic void add(rec_t r, string t);
        plan_q.push_back(r);
        ptag_q.push_back(t);
    endfunction

    function automatic rec_t rst_rec();
        rec_t r = '0;
        r.rb_w  = 1'b1;
        r.wreg  = 2'd2;
        r.wdata = 3'd7;
        return r;
    endfunction

    function automatic rec_t exc_rec();
        rec_t r = '0;
        r.b_sel   = 2'd1;
        r.ula     = 3'b010;
        r.epc_w   = 1'b1;
        r.out_sel = 3'd4;
        r.pc_w    = 1'b1;
        return r;
    endfunction

    function automatic rec_t alu_rec(logic a, logic [1:0] b, logic [2:0] ula);
        rec_t r = '0;
        r.a_sel = a;
        r.b_sel = b;
        r.ula   = ula;
        r.alu_w = 1'b1;
        return r;
    endfunction

    function automatic rec_t wb_rec(logic [1:0] wreg, logic [2:0] wdata);
        rec_t r = '0;
        r.rb_w  = 1'b1;
        r.wreg  = wreg;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic void model_instr(logic [5:0] op, logic [5:0] fn, logic of, logic eq);
        rec_t r;
        logic legal;
        logic traps;
        logic [2:0] ula;
        r = '0;
        add(r, "F0");
        add(r, "F1");
        r = '0;
        r.ir_w = 1'b1; r.b_sel = 2'd1; r.ula = 3'b001; r.pc_w = 1'b1;
        add(r, "F2");
        r = alu_rec(1'b0, 2'd3, 3'b001);
        r.ab_w = 1'b1;
        add(r, "DEC");
        if (op == 6'h00) begin
            legal = 1'b1;
            traps = 1'b0;
            ula = 3'b000;
            if (fn == 6'h20) begin ula = 3'b001; traps = of; end
            else if (fn == 6'h22) begin ula = 3'b010; traps = of; end
            else if (fn == 6'h24) ula = 3'b011;
            else legal = 1'b0;
            add(alu_rec(1'b1, 2'd0, ula), "EX_R");
            if (!legal || traps) add(exc_rec(), "EXC");
            else add(wb_rec(2'd1, 3'd0), "WB_R");
        end else if (op == 6'h08) begin
            add(alu_rec(1'b1, 2'd2, 3'b001), "EX_I");
            if (of) add(exc_rec(), "EXC");
            else add(wb_rec(2'd0, 3'd0), "WB_I");
        end else if (op == 6'h23 || op == 6'h2B) begin
            add(alu_rec(1'b1, 2'd2, 3'b001), "ADDR");
            r = '0;
            r.mem_sel = 2'd1;
            if (op == 6'h23) begin
                add(r, "LW0");
                add(r, "LW1");
                add(wb_rec(2'd0, 3'd1), "LW_WB");
            end else begin
                r.mem_w = 1'b1;
                add(r, "SW");
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            r = '0;
            r.a_sel = 1'b1; r.ula = 3'b111; r.out_sel = 3'd1;
            r.pc_w = (op == 6'h04) ? eq : !eq;
            add(r, "BRANCH");
        end else if (op == 6'h02) begin
            r = '0;
            r.out_sel = 3'd2; r.pc_w = 1'b1;
            add(r, "JUMP");
        end else begin
            add(exc_rec(), "EXC");
        end
    endfunction

    // ---------------- driver helpers ----------------
    task automatic step(rec_t e, string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic play(int n);
        for (int i = 0; i < n; i++) begin
            if (plan_q.size() > 0) step(plan_q.pop_front(), ptag_q.pop_front());
        end
    endtask

    task automatic pin(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic start(logic [5:0] op, logic [5:0] fn, logic of, logic eq);
        bus.OPCODE = op;
        bus.FUNCT  = fn;
        bus.Of     = of;
        bus.Eq     = eq;
        obs.delete();
        model_instr(op, fn, of, eq);
    endtask

    task automatic run(logic [5:0] op, logic [5:0] fn, logic of, logic eq);
        start(op, fn, of, eq);
        play(plan_q.size());
    endtask

    function automatic int count_mem_w();
        int n = 0;
        foreach (obs[i]) n += int'(obs[i].mem_w);
        return n;
    endfunction

    function automatic int count_rb_w();
        int n = 0;
        foreach (obs[i]) n += int'(obs[i].rb_w);
        return n;
    endfunction

    function automatic int count_wdata_load();
        int n = 0;
        foreach (obs[i]) n += int'(obs[i].wdata == 3'd1);
        return n;
    endfunction

    initial begin
        bus.OPCODE = 6'h00;
        bus.FUNCT  = 6'h00;
        bus.Of     = 1'b0;
        bus.Eq     = 1'b0;
        reset      = 1'b0;
        @(posedge clk);
        #1;
        // Three cycles in reset, then exactly one RST cycle after release.
        for (int i = 0; i < 3; i++) step(rst_rec(), "RST_hold");
        reset = 1'b1;
        obs.delete();
        step(rst_rec(), "RST_once");
        pin("rst_writereg", int'(obs[0].wreg), 2);
        pin("rst_wdata", int'(obs[0].wdata), 7);

        // R-type add, no overflow: six cycles ending in WB_R.
        start(6'h00, 6'h20, 1'b0, 1'b0);
        pin("model_rtype_len", plan_q.size(), 6);
        play(plan_q.size());
        pin("add_f2_irw", int'(obs[2].ir_w), 1);
        pin("add_f2_pcw", int'(obs[2].pc_w), 1);
        pin("add_ex_ula", int'(obs[4].ula), 1);
        pin("add_wb_rbw", int'(obs[5].rb_w), 1);
        pin("add_wb_wreg", int'(obs[5].wreg), 1);

        run(6'h00, 6'h22, 1'b1, 1'b0);     // sub overflow -> EXC
        pin("sub_of_epc", int'(obs[5].epc_w), 1);
        run(6'h00, 6'h24, 1'b1, 1'b0);     // and ignores overflow
        pin("and_wb_rbw", int'(obs[5].rb_w), 1);
        run(6'h00, 6'h3F, 1'b0, 1'b0);     // illegal funct
        run(6'h08, 6'h00, 1'b0, 1'b0);     // addi
        pin("addi_wb_wreg", int'(obs[5].wreg), 0);

        run(6'h08, 6'h00, 1'b1, 1'b0);     // addi overflow
        pin("addi_of_epc", int'(obs[5].epc_w), 1);
        pin("addi_of_pcw", int'(obs[5].pc_w), 1);
        pin("addi_of_vec", int'(obs[5].out_sel), 4);
        pin("addi_of_no_rbw", count_rb_w(), 0);

        run(6'h04, 6'h00, 1'b0, 1'b1);
        pin("beq_taken_pcw", int'(obs[4].pc_w), 1);
        pin("beq_taken_sel", int'(obs[4].out_sel), 1);
        run(6'h04, 6'h00, 1'b0, 1'b0);
        pin("beq_nt_pcw", int'(obs[4].pc_w), 0);
        run(6'h05, 6'h00, 1'b0, 1'b1);
        pin("bne_nt_pcw", int'(obs[4].pc_w), 0);
        run(6'h05, 6'h00, 1'b0, 1'b0);
        pin("bne_taken_pcw", int'(obs[4].pc_w), 1);

        run(6'h2B, 6'h00, 1'b1, 1'b0);
        pin("sw_memw_once", count_mem_w(), 1);
        pin("sw_mem_sel", int'(obs[5].mem_sel), 1);

        run(6'h23, 6'h00, 1'b0, 1'b0);
        pin("lw_len", obs.size(), 8);
        pin("lw_c8_wdata", int'(obs[7].wdata), 1);
        pin("lw_c8_rbw", int'(obs[7].rb_w), 1);

        run(6'h02, 6'h00, 1'b0, 1'b0);
        pin("j_sel", int'(obs[4].out_sel), 2);

        run(6'h3F, 6'h00, 1'b0, 1'b0);
        pin("illegal_epc", int'(obs[4].epc_w), 1);
        pin("illegal_no_rbw", count_rb_w(), 0);

        // Load aborted by reset during LW1.
        start(6'h23, 6'h00, 1'b0, 1'b0);
        play(6);
        plan_q.delete();
        ptag_q.delete();
        reset = 1'b0;
        step(rst_rec(), "RST_mid");
        reset = 1'b1;
        step(rst_rec(), "RST_after_abort");
        pin("abort_no_memw", count_mem_w(), 0);
        pin("abort_no_lw_wb", count_wdata_load(), 0);

        run(6'h00, 6'h20, 1'b0, 1'b0);     // fetch resumes cleanly

        pin("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
